fifo_wide_to_narrow: RTL

Parametrised width-converting FIFO. It buffers IN_WIDTH-bit words and emits them as a sequence of OUT_WIDTH-bit segments, with the segment order selectable. It is the successor to the fixed 43-to-16 MISO FIFO and adds:
- valid/ready handshakes on both sides;
- full throughput of one segment per cycle;
- a segment index and last-segment flag;
- a synchronous flush.
It sits between wide producers (packet/feature formers) and narrow serial or bus-facing consumers.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_seg_select.sv | 43 ++++
 rtl/fifo_wide_to_narrow.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and constants for the width-converting FIFO.
package fifo_pkg;

  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fifo_seg_select.sv
// Combinational segment picker: maps a stored word and a segment index to one output segment.
module fifo_seg_select
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 43,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned NUM_SEG  = ceil_div(IN_WIDTH, OUT_WIDTH),
  localparam int unsigned SEG_W    = (clog2(NUM_SEG) > 1) ? clog2(NUM_SEG) : 1,
  localparam int unsigned PAD      = NUM_SEG * OUT_WIDTH - IN_WIDTH,
  localparam int unsigned REM_W    = OUT_WIDTH - PAD,
  localparam int unsigned TOT_W    = NUM_SEG * OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  word,
  input  logic [SEG_W-1:0]     seg_idx,
  output logic [OUT_WIDTH-1:0] seg
);

  logic [OUT_WIDTH-1:0] segs [NUM_SEG];

  // MSB-first keeps the short remainder as a right-aligned tail segment.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    if (MSB_FIRST == MSB_FIRST_ORDER) begin : g_msb
      if (k == NUM_SEG - 1) begin : g_tail
        assign segs[k] = OUT_WIDTH'(word[REM_W-1:0]);
      end else begin : g_body
        assign segs[k] = word[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
      end
    end else if (MSB_FIRST == LSB_FIRST_ORDER) begin : g_lsb
      logic [TOT_W-1:0] padded;
      assign padded  = TOT_W'(word);
      assign segs[k] = padded[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    seg = '0;
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      if (seg_idx == SEG_W'(k)) seg = segs[k];
    end
  end

endmodule

// File: rtl/fifo_wide_to_narrow.sv
// Width-converting FIFO: stores wide words, emits them as narrow registered segments
// with valid/ready on both sides and a synchronous flush.
module fifo_wide_to_narrow
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 43,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned NUM_SEG  = ceil_div(IN_WIDTH, OUT_WIDTH),
  localparam int unsigned SEG_W    = (clog2(NUM_SEG) > 1) ? clog2(NUM_SEG) : 1,
  localparam int unsigned CNT_W    = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [SEG_W-1:0]     out_seg_idx,
  output logic                 out_last,
  output logic [CNT_W-1:0]     word_count,
  output logic                 fifo_full,
  output logic                 fifo_empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [IN_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [SEG_W-1:0]     seg_ptr;
  logic [CNT_W-1:0]     count_nxt;
  logic [OUT_WIDTH-1:0] seg_word;
  logic                 wr_en, stage_free, load, seg_last, pop;

  fifo_seg_select #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_seg_select (
    .word   (mem[rd_ptr]),
    .seg_idx(seg_ptr),
    .seg    (seg_word)
  );

  always_comb begin
    wr_en      = in_valid && in_ready && !rst && !flush;
    stage_free = !out_valid || out_ready;
    load       = stage_free && !fifo_empty;
    seg_last   = (seg_ptr == SEG_W'(NUM_SEG - 1));
    pop        = load && seg_last;
    count_nxt  = word_count + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ptr_nxt = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    rd_ptr_nxt = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      seg_ptr     <= '0;
      word_count  <= '0;
      fifo_full   <= 1'b0;
      fifo_empty  <= 1'b1;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_seg_idx <= '0;
      out_last    <= 1'b0;
      if (rst) out_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr_nxt;
      // A word leaves storage when its final segment enters the output stage.
      if (load) begin
        out_data    <= seg_word;
        out_seg_idx <= seg_ptr;
        out_last    <= seg_last;
        out_valid   <= 1'b1;
        if (seg_last) begin
          seg_ptr <= '0;
          rd_ptr  <= rd_ptr_nxt;
        end else begin
          seg_ptr <= seg_ptr + SEG_W'(1);
        end
      end else if (stage_free) begin
        out_valid <= 1'b0;
      end
      word_count <= count_nxt;
      fifo_full  <= (count_nxt == CNT_W'(DEPTH));
      fifo_empty <= (count_nxt == '0);
      in_ready   <= (count_nxt != CNT_W'(DEPTH));
    end
  end

endmodule
